// File: rtl/tv_recorder.sv
// Test-vector recorder: captures one word per enabled cycle into a buffer, then
// streams the session back in capture order on a valid/ready port.
module tv_recorder #(
    parameter int N        = 32,
    parameter int TV_WIDTH = 3 * N,
    parameter int TV_LEN   = 100,
    parameter int AW       = 7
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stop,
    input  logic                sample_en,
    input  logic [TV_WIDTH-1:0] sample_data,
    input  logic                rd_ready,
    output logic                rd_valid,
    output logic [TV_WIDTH-1:0] rd_data,
    output logic                rd_last,
    output logic [AW:0]         count,
    output logic                busy,
    output logic                done,
    output logic                overflow
);

    // Handshake: a word moves on every rising clk edge where rd_valid && rd_ready.
    // While rd_valid && !rd_ready, rd_data and rd_last are frozen, and rd_valid
    // stays high until that word moves.

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [AW:0] LEN    = (AW + 1)'(TV_LEN);
    localparam logic [AW:0] LEN_M1 = (AW + 1)'(TV_LEN - 1);

    state_t              state;
    logic [TV_WIDTH-1:0] mem [TV_LEN];
    logic [AW:0]         rd_idx;
    logic                wr_en;
    logic                full;

    assign full  = (count == LEN);
    assign wr_en = (state == CAPTURE) && sample_en && !full;

    // Buffer storage carries no reset so it can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[count[AW-1:0]] <= sample_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            overflow <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_last  <= 1'b0;
            rd_idx   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state    <= CAPTURE;
                        count    <= '0;
                        overflow <= 1'b0;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                    end
                end

                CAPTURE: begin
                    if (wr_en) begin
                        count <= count + 1'b1;
                    end
                    if (sample_en && full) begin
                        overflow <= 1'b1;
                    end
                    // The filling write ends capture even without stop.
                    if ((wr_en && count == LEN_M1) ||
                        (stop && (count != '0 || wr_en))) begin
                        state  <= DRAIN;
                        rd_idx <= '0;
                    end else if (stop) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end

                DRAIN: begin
                    // Samples still arriving after an auto-drain are the dropped ones.
                    if (sample_en && full) begin
                        overflow <= 1'b1;
                    end
                    if (!rd_valid) begin
                        rd_data  <= mem[0];
                        rd_last  <= (count == 1);
                        rd_valid <= 1'b1;
                        rd_idx   <= 1;
                    end else if (rd_ready) begin
                        if (rd_last) begin
                            state    <= DONE;
                            rd_valid <= 1'b0;
                            rd_last  <= 1'b0;
                            rd_data  <= '0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                        end else begin
                            rd_data <= mem[rd_idx[AW-1:0]];
                            rd_last <= (rd_idx == count - 1'b1);
                            rd_idx  <= rd_idx + 1'b1;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tv_recorder.sv
// Directed bench for tv_recorder with a 4-deep buffer so the full/overflow
// boundary is reachable in a few cycles.
module tb_tv_recorder;

    localparam int N   = 32;
    localparam int TVW = 3 * N;
    localparam int LEN = 4;
    localparam int AW  = 7;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           stop;
    logic           sample_en;
    logic [TVW-1:0] sample_data;
    logic           rd_ready;
    logic           rd_valid;
    logic [TVW-1:0] rd_data;
    logic           rd_last;
    logic [AW:0]    count;
    logic           busy;
    logic           done;
    logic           overflow;

    int n_cmp = 0;
    int n_bad = 0;

    logic [TVW-1:0] got_q [$];
    int             last_pos;
    int             first_valid_c;
    int             unstable;
    int             bubbles;
    int             timed_out;

    tv_recorder #(.N(N), .TV_WIDTH(TVW), .TV_LEN(LEN), .AW(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .sample_en(sample_en), .sample_data(sample_data),
        .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
        .rd_last(rd_last), .count(count), .busy(busy), .done(done),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are then read 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input logic [TVW-1:0] d);
        sample_en   = 1'b1;
        sample_data = d;
        step();
        sample_en   = 1'b0;
    endtask

    // Drives rd_ready (steady or alternating 1,0,...) and gathers every transferred
    // word plus handshake observations until the rd_last transfer or a cycle bound.
    task automatic collect(input bit alternate);
        logic [TVW-1:0] held;
        logic           held_last;
        bit             holding;
        bit             seen;
        bit             fin;
        got_q.delete();
        last_pos = -1;
        first_valid_c = -1;
        unstable = 0;
        bubbles = 0;
        timed_out = 1;
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            rd_ready = alternate ? (c % 2 == 0) : 1'b1;
            if (rd_valid && !seen) begin
                seen = 1;
                first_valid_c = c;
            end
            if (seen && !rd_valid) bubbles++;
            holding = rd_valid && !rd_ready;
            held = rd_data;
            held_last = rd_last;
            fin = 0;
            if (rd_valid && rd_ready) begin
                got_q.push_back(rd_data);
                if (rd_last) begin
                    last_pos = got_q.size() - 1;
                    fin = 1;
                end
            end
            step();
            if (holding && (!rd_valid || rd_data !== held || rd_last !== held_last))
                unstable++;
            if (fin) begin
                timed_out = 0;
                break;
            end
        end
        rd_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 0; stop = 0; sample_en = 0; sample_data = '0; rd_ready = 0;
        step(); step();
        rst = 1'b0;
        n_cmp++;
        if ({rd_valid, rd_data, rd_last, count, busy, done, overflow} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got valid=%b data=%h last=%b count=%0d busy=%b done=%b ovf=%b, want all 0",
                     rd_valid, rd_data, rd_last, count, busy, done, overflow);
        end
    endtask

    task automatic test_basic();
        start = 1; step(); start = 0;
        n_cmp++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_bad++; $display("FAIL basic_capture_busy: busy=%b done=%b, want 1 0", busy, done);
        end
        sample(96'h1); sample(96'h2); sample(96'h3);
        stop = 1; step(); stop = 0;
        n_cmp++;
        if (count !== 8'd3) begin
            n_bad++; $display("FAIL basic_count: got %0d want 3", count);
        end
        collect(0);
        n_cmp++;
        if (timed_out != 0 || got_q.size() != 3 || got_q[0] !== 96'h1 || got_q[1] !== 96'h2 || got_q[2] !== 96'h3) begin
            n_bad++; $display("FAIL basic_stream: got %0d words (timeout=%0d), want 1,2,3", got_q.size(), timed_out);
        end
        n_cmp++;
        if (last_pos != 2 || bubbles != 0) begin
            n_bad++; $display("FAIL basic_last_nobubble: last at %0d bubbles %0d, want 2 and 0", last_pos, bubbles);
        end
        n_cmp++;
        if (first_valid_c < 0 || first_valid_c > 2) begin
            n_bad++; $display("FAIL basic_valid_latency: first valid at cycle %0d, want 0..2", first_valid_c);
        end
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0 || rd_valid !== 1'b0 || count !== 8'd3) begin
            n_bad++; $display("FAIL basic_done: done=%b busy=%b valid=%b count=%0d, want 1 0 0 3", done, busy, rd_valid, count);
        end
    endtask

    task automatic test_backpressure();
        start = 1; step(); start = 0;
        sample(96'h1); sample(96'h2); sample(96'h3);
        stop = 1; step(); stop = 0;
        collect(1);
        n_cmp++;
        if (timed_out != 0 || got_q.size() != 3 || got_q[0] !== 96'h1 || got_q[1] !== 96'h2 || got_q[2] !== 96'h3) begin
            n_bad++; $display("FAIL bp_stream: got %0d words (timeout=%0d), want 1,2,3", got_q.size(), timed_out);
        end
        n_cmp++;
        if (unstable != 0 || last_pos != 2) begin
            n_bad++; $display("FAIL bp_stable: unstable stalls %0d last at %0d, want 0 and 2", unstable, last_pos);
        end
    endtask

    task automatic test_overflow();
        start = 1; step(); start = 0;
        for (int i = 1; i <= 6; i++) sample(TVW'(i));
        n_cmp++;
        if (overflow !== 1'b1 || count !== 8'd4 || busy !== 1'b1) begin
            n_bad++; $display("FAIL ovf_flags: ovf=%b count=%0d busy=%b, want 1 4 1", overflow, count, busy);
        end
        collect(0);
        n_cmp++;
        if (timed_out != 0 || got_q.size() != 4 || got_q[0] !== 96'h1 || got_q[1] !== 96'h2 ||
            got_q[2] !== 96'h3 || got_q[3] !== 96'h4 || last_pos != 3) begin
            n_bad++; $display("FAIL ovf_stream: got %0d words last at %0d (timeout=%0d), want 1..4", got_q.size(), last_pos, timed_out);
        end
        n_cmp++;
        if (overflow !== 1'b1 || done !== 1'b1) begin
            n_bad++; $display("FAIL ovf_sticky: ovf=%b done=%b, want 1 1", overflow, done);
        end
    endtask

    task automatic test_empty_session();
        int vseen;
        start = 1; step(); start = 0;
        n_cmp++;
        if (overflow !== 1'b0 || count !== 8'd0) begin
            n_bad++; $display("FAIL empty_start_clear: ovf=%b count=%0d, want 0 0", overflow, count);
        end
        stop = 1; step(); stop = 0;
        vseen = rd_valid;
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0 || count !== 8'd0) begin
            n_bad++; $display("FAIL empty_done: done=%b busy=%b count=%0d, want 1 0 0", done, busy, count);
        end
        rd_ready = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            if (rd_valid) vseen++;
        end
        rd_ready = 0;
        n_cmp++;
        if (vseen != 0) begin
            n_bad++; $display("FAIL empty_no_valid: rd_valid seen %0d cycles, want 0", vseen);
        end
    endtask

    task automatic test_mid_reset();
        start = 1; step(); start = 0;
        sample(96'h7); sample(96'h8); sample(96'h9);
        stop = 1; step(); stop = 0;
        rd_ready = 1;
        step();
        step();
        rd_ready = 0;
        rst = 1; step(); rst = 0;
        n_cmp++;
        if ({rd_valid, rd_data, rd_last, count, busy, done, overflow} !== '0) begin
            n_bad++;
            $display("FAIL midrst_outputs: valid=%b data=%h last=%b count=%0d busy=%b done=%b ovf=%b, want all 0",
                     rd_valid, rd_data, rd_last, count, busy, done, overflow);
        end
        start = 1; step(); start = 0;
        sample(96'hA); sample(96'hB);
        stop = 1; step(); stop = 0;
        collect(0);
        n_cmp++;
        if (timed_out != 0 || got_q.size() != 2 || got_q[0] !== 96'hA || got_q[1] !== 96'hB || last_pos != 1) begin
            n_bad++; $display("FAIL midrst_session: got %0d words last at %0d (timeout=%0d), want A,B", got_q.size(), last_pos, timed_out);
        end
    endtask

    task automatic test_stray_controls();
        rst = 1; step(); rst = 0;
        sample(96'h55);
        n_cmp++;
        if (count !== 8'd0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL stray_idle_sample: count=%0d busy=%b, want 0 0", count, busy);
        end
        start = 1; stop = 1; step(); start = 0; stop = 0;
        n_cmp++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_bad++; $display("FAIL stray_start_wins: busy=%b done=%b, want 1 0", busy, done);
        end
        sample(96'h11);
        start = 1; sample(96'h22); start = 0;
        n_cmp++;
        if (count !== 8'd2) begin
            n_bad++; $display("FAIL stray_no_restart: count=%0d, want 2", count);
        end
        stop = 1; step(); stop = 0;
        collect(0);
        sample(96'h33);
        n_cmp++;
        if (count !== 8'd2 || done !== 1'b1 || got_q.size() != 2 || got_q[0] !== 96'h11 || got_q[1] !== 96'h22) begin
            n_bad++; $display("FAIL stray_done_sample: count=%0d done=%b words=%0d, want 2 1 2 (11,22)", count, done, got_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_overflow();
        test_empty_session();
        test_mid_reset();
        test_stray_controls();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
